cva6_ptw_sv32: RTL

CVA6_PTW_SV32 -- requirements
Module: cva6_ptw_sv32

---
 rtl/cva6_ptw_sv32.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cva6_ptw_sv32.sv
// Sv32 page-table walker.
// Resolves a TLB miss by reading one or two PTEs from memory, then either
// emits a single-cycle TLB update or a single-cycle page-fault pulse.
//
// state        | meaning
// -------------+--------------------------------------------------------
// S_IDLE       | no walk; request can be accepted
// S_WAIT_GNT   | PTE read requested, waiting for memory grant
// S_WAIT_RVALID| read granted, waiting for PTE data
// S_UPDATE     | one-cycle TLB update pulse
// S_FAULT      | one-cycle page-fault pulse
// S_DRAIN      | walk aborted after grant; swallow the outstanding response
module cva6_ptw_sv32 (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        miss_valid_i,
   output logic        miss_ready_o,
   input  logic [31:0] miss_vaddr_i,
   input  logic [8:0]  miss_asid_i,
   input  logic [21:0] satp_ppn_i,
   output logic        mem_req_o,
   output logic [33:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [62:0] update_o,
   output logic        busy_o,
   output logic        pf_o,
   output logic [31:0] pf_vaddr_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_GNT,
      S_WAIT_RVALID,
      S_UPDATE,
      S_FAULT,
      S_DRAIN
   } state_e;

   state_e      state_q;
   state_e      state_d;

   logic        level_q;     // 1 = root level, 0 = leaf level
   logic        is_4m_q;
   logic [31:0] vaddr_q;
   logic [8:0]  asid_q;
   logic [31:0] pte_q;
   logic [33:0] addr_q;
   logic [31:0] pf_vaddr_q;

   logic        pte_v;
   logic        pte_r;
   logic        pte_w;
   logic        pte_x;
   logic        pte_bad;
   logic        pte_leaf;
   logic        pte_misaligned;
   logic        accept;
   logic        resp_take;

   // PTE field decode of the incoming read data
   always_comb begin
      pte_v          = mem_rdata_i[0];
      pte_r          = mem_rdata_i[1];
      pte_w          = mem_rdata_i[2];
      pte_x          = mem_rdata_i[3];
      pte_bad        = !pte_v || (!pte_r && pte_w);
      pte_leaf       = pte_r || pte_x;
      pte_misaligned = (mem_rdata_i[19:10] != 10'd0);
      accept         = (state_q == S_IDLE) && miss_valid_i && !flush_i;
      resp_take      = (state_q == S_WAIT_RVALID) && mem_rvalid_i && !flush_i;
   end

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; flush always takes priority over progress
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_WAIT_GNT;
            end
         end
         S_WAIT_GNT: begin
            if (mem_gnt_i) begin
               // a granted read still owes a response, so a flush must drain it
               state_d = flush_i ? S_DRAIN : S_WAIT_RVALID;
            end else if (flush_i) begin
               state_d = S_IDLE;
            end
         end
         S_WAIT_RVALID: begin
            if (flush_i) begin
               // response arriving in the flush cycle is already consumed
               state_d = mem_rvalid_i ? S_IDLE : S_DRAIN;
            end else if (mem_rvalid_i) begin
               if (pte_bad) begin
                  state_d = S_FAULT;
               end else if (pte_leaf) begin
                  if (level_q && pte_misaligned) begin
                     state_d = S_FAULT;
                  end else begin
                     state_d = S_UPDATE;
                  end
               end else if (level_q) begin
                  state_d = S_WAIT_GNT;
               end else begin
                  state_d = S_FAULT;
               end
            end
         end
         S_UPDATE: state_d = S_IDLE;
         S_FAULT:  state_d = S_IDLE;
         S_DRAIN: begin
            if (mem_rvalid_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from the current state
   always_comb begin
      miss_ready_o = (state_q == S_IDLE);
      busy_o       = (state_q != S_IDLE);
      mem_req_o    = (state_q == S_WAIT_GNT);
      mem_addr_o   = addr_q;
      pf_vaddr_o   = pf_vaddr_q;
      pf_o         = (state_q == S_FAULT) && !flush_i;
      update_o     = 63'd0;
      if ((state_q == S_UPDATE) && !flush_i) begin
         update_o = {1'b1, is_4m_q, vaddr_q[31:12], asid_q, pte_q};
      end
   end

   // Walk datapath: captured request, PTE address, PTE data, fault address
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         level_q    <= 1'b1;
         is_4m_q    <= 1'b0;
         vaddr_q    <= 32'd0;
         asid_q     <= 9'd0;
         pte_q      <= 32'd0;
         addr_q     <= 34'd0;
         pf_vaddr_q <= 32'd0;
      end else begin
         if (accept) begin
            vaddr_q <= miss_vaddr_i;
            asid_q  <= miss_asid_i;
            level_q <= 1'b1;
            addr_q  <= {satp_ppn_i, miss_vaddr_i[31:22], 2'b00};
         end
         if (resp_take) begin
            pte_q   <= mem_rdata_i;
            is_4m_q <= level_q;
            if (!pte_bad && !pte_leaf && level_q) begin
               level_q <= 1'b0;
               addr_q  <= {mem_rdata_i[31:10], vaddr_q[21:12], 2'b00};
            end
         end
         // loaded on entry so the address is valid alongside the pulse
         if ((state_d == S_FAULT) && (state_q != S_FAULT)) begin
            pf_vaddr_q <= vaddr_q;
         end
      end
   end

endmodule
